// File: rtl/zle_dec_xcb_pkg.sv
// Zero run-length decoder: shared constants and state encoding.
// Token = {run_flag, field}; field is a literal value or a zero count.
package zle_dec_xcb_pkg;

  localparam int unsigned ZLE_W   = 7;
  localparam int unsigned RUN_BIT = ZLE_W;
  localparam int unsigned CNT_W   = ZLE_W;
  localparam int unsigned MAX_CNT = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/zle_dec_xcb_dp.sv
// Decoder datapath: output data register and pending-zero counter.
// rem_eq_0_o looks at the counter value being written this cycle.
module zle_dec_xcb_dp
  import zle_dec_xcb_pkg::*;
#(
  parameter int W = ZLE_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_lit_i,
  input  logic         load_run_i,
  input  logic         dec_i,
  input  logic [W-1:0] cnt_i,
  output logic [W-1:0] d_o,
  output logic         rem_eq_0_o,
  output logic         cnt_eq_0_o
);

  logic [W-1:0] d_q, d_d;
  logic [W-1:0] rem_q, rem_d;

  always_comb begin
    d_d   = d_q;
    rem_d = rem_q;
    if (load_lit_i) begin
      d_d = cnt_i;
    end else if (load_run_i) begin
      d_d   = '0;
      rem_d = cnt_i - W'(1);
    end else if (dec_i) begin
      rem_d = rem_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_q   <= '0;
      rem_q <= '0;
    end else begin
      d_q   <= d_d;
      rem_q <= rem_d;
    end
  end

  assign d_o        = d_q;
  assign rem_eq_0_o = (rem_d == '0);
  assign cnt_eq_0_o = (cnt_i == '0);

endmodule

// File: rtl/zle_dec_xcb.sv
// Zero run-length decoder: literals pass through, runs expand to zeros.
// Control FSM lives here; data and counter live in the _dp block.
module zle_dec_xcb
  import zle_dec_xcb_pkg::*;
#(
  parameter int W = ZLE_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W:0]   i_d,
  input  logic         i_v,
  output logic         i_b,
  output logic [W-1:0] o_d,
  output logic         o_v,
  input  logic         o_b,
  output logic         err
);

  state_e state_q, state_d;
  logic   err_q;
  logic   accept, out_fire, is_run;
  logic   lit_acc, run_acc, bad_acc, dec;
  logic   rem_eq_0, cnt_eq_0;

  assign is_run   = i_d[W];
  assign accept   = i_v & ~i_b;
  assign out_fire = o_v & ~o_b;
  assign lit_acc  = accept & ~is_run;
  assign run_acc  = accept & is_run & ~cnt_eq_0;
  assign bad_acc  = accept & is_run & cnt_eq_0;
  assign dec      = (state_q == ST_RUN) & out_fire;

  zle_dec_xcb_dp #(.W(W)) u_dp (
    .clk_i      (clock),
    .rst_ni     (reset),
    .load_lit_i (lit_acc),
    .load_run_i (run_acc),
    .dec_i      (dec),
    .cnt_i      (i_d[W-1:0]),
    .d_o        (o_d),
    .rem_eq_0_o (rem_eq_0),
    .cnt_eq_0_o (cnt_eq_0)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | bad_acc;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (lit_acc)      state_d = ST_HOLD;
        else if (run_acc) state_d = rem_eq_0 ? ST_HOLD : ST_RUN;
      end
      ST_HOLD: begin
        if (out_fire) begin
          if (lit_acc)      state_d = ST_HOLD;
          else if (run_acc) state_d = rem_eq_0 ? ST_HOLD : ST_RUN;
          else              state_d = ST_EMPTY;
        end
      end
      ST_RUN: begin
        if (out_fire && rem_eq_0) state_d = ST_HOLD;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Reset forces i_b low so tokens offered during reset are dropped.
  always_comb begin
    o_v = (state_q != ST_EMPTY);
    i_b = reset & ((state_q == ST_RUN) | (o_v & o_b));
  end

  assign err = err_q;

endmodule

// File: tb/tb_zle_dec_xcb.sv
// Self-checking bench for zle_dec_xcb: vector table, corner sequences,
// and random traffic against a token-expansion queue model.
module tb_zle_dec_xcb;

  localparam int W = 7;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W:0]   i_d   = '0;
  logic         i_v   = 1'b0;
  logic         i_b;
  logic [W-1:0] o_d;
  logic         o_v;
  logic         o_b   = 1'b0;
  logic         err;

  zle_dec_xcb #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .i_d   (i_d),
    .i_v   (i_v),
    .i_b   (i_b),
    .o_d   (o_d),
    .o_v   (o_v),
    .o_b   (o_b),
    .err   (err)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       ob;
    logic       ib;
    logic       ov;
    logic [6:0] od;
    logic       er;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d, input logic v,
                              input logic ob, input logic ib,
                              input logic ov, input logic [6:0] od,
                              input logic er);
    vec_t r;
    r.d = d; r.v = v; r.ob = ob; r.ib = ib;
    r.ov = ov; r.od = od; r.er = er;
    return r;
  endfunction

  vec_t       tv[$];
  logic [7:0] tokq[$];
  logic [6:0] outq[$];
  logic [6:0] expq[$];

  task automatic do_reset();
    reset = 1'b0;
    i_v   = 1'b1;
    i_d   = 8'h84;
    o_b   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst i_b", 32'(i_b), 32'd0);
    check("rst o_v", 32'(o_v), 32'd0);
    check("rst o_d", 32'(o_d), 32'd0);
    check("rst err", 32'(err), 32'd0);
    reset = 1'b1;
    i_v   = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Drive queued tokens, collect transferred outputs.
  task automatic feed_cycle();
    logic acc;
    i_v = (tokq.size() > 0);
    i_d = (tokq.size() > 0) ? tokq[0] : 8'h00;
    @(negedge clock);
    if (o_v && !o_b) outq.push_back(o_d);
    acc = i_v && !i_b;
    @(posedge clock);
    #1;
    if (acc) void'(tokq.pop_front());
    i_v = 1'b0;
  endtask

  initial begin
    int zeros;
    bit exp_err;
    logic [7:0] tok;

    do_reset();

    // literals back to back
    tv.push_back(mk(8'h05, 1, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(8'h7F, 1, 0, 0, 1, 7'h05, 0));
    tv.push_back(mk(8'h00, 1, 0, 0, 1, 7'h7F, 0));
    tv.push_back(mk(8'h00, 0, 0, 0, 1, 7'h00, 0));
    tv.push_back(mk(8'h00, 0, 0, 0, 0, 7'h00, 0));
    // run of 3 then literal 0x11
    tv.push_back(mk(8'h83, 1, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(8'h11, 1, 0, 1, 1, 7'h00, 0));
    tv.push_back(mk(8'h11, 1, 0, 1, 1, 7'h00, 0));
    tv.push_back(mk(8'h11, 1, 0, 0, 1, 7'h00, 0));
    tv.push_back(mk(8'h00, 0, 0, 0, 1, 7'h11, 0));
    tv.push_back(mk(8'h00, 0, 0, 0, 0, 7'h00, 0));
    // malformed run between literals
    tv.push_back(mk(8'h02, 1, 0, 0, 0, 7'h00, 0));
    tv.push_back(mk(8'h80, 1, 0, 0, 1, 7'h02, 0));
    tv.push_back(mk(8'h03, 1, 0, 0, 0, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 1, 7'h03, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 0, 7'h00, 1));
    // run of 4 with a 5-cycle stall
    tv.push_back(mk(8'h84, 1, 0, 0, 0, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 1, 1, 7'h00, 1));
    for (int s = 0; s < 5; s++)
      tv.push_back(mk(8'h00, 0, 1, 1, 1, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 1, 1, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 1, 1, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 1, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 0, 7'h00, 1));
    // held literal under back-pressure
    tv.push_back(mk(8'h22, 1, 0, 0, 0, 7'h00, 1));
    tv.push_back(mk(8'h33, 1, 1, 1, 1, 7'h22, 1));
    tv.push_back(mk(8'h33, 1, 0, 0, 1, 7'h22, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 1, 7'h33, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 0, 7'h00, 1));
    // single-zero run
    tv.push_back(mk(8'h81, 1, 0, 0, 0, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 1, 7'h00, 1));
    tv.push_back(mk(8'h00, 0, 0, 0, 0, 7'h00, 1));

    for (int k = 0; k < tv.size(); k++) begin
      i_d = tv[k].d;
      i_v = tv[k].v;
      o_b = tv[k].ob;
      @(negedge clock);
      check($sformatf("v%0d i_b", k), 32'(i_b), 32'(tv[k].ib));
      check($sformatf("v%0d o_v", k), 32'(o_v), 32'(tv[k].ov));
      if (tv[k].ov)
        check($sformatf("v%0d o_d", k), 32'(o_d), 32'(tv[k].od));
      check($sformatf("v%0d err", k), 32'(err), 32'(tv[k].er));
      @(posedge clock);
      #1;
    end
    i_v = 1'b0;
    o_b = 1'b0;

    // maximum run then literal
    do_reset();
    tokq = '{8'hFF, 8'h01};
    outq.delete();
    for (int c = 0; c < 200 && outq.size() < 128; c++) feed_cycle();
    check("max run outputs", 32'(outq.size()), 32'd128);
    zeros = 0;
    foreach (outq[j]) if (j < 127 && outq[j] == 7'h00) zeros++;
    check("max run zeros", 32'(zeros), 32'd127);
    if (outq.size() == 128)
      check("max run tail", 32'(outq[127]), 32'h01);
    check("max run err", 32'(err), 32'd0);

    // reset aborts a run
    tokq = '{8'h80, 8'h90};
    outq.delete();
    for (int c = 0; c < 50 && outq.size() < 3; c++) feed_cycle();
    check("abort zeros seen", 32'(outq.size()), 32'd3);
    check("abort err set", 32'(err), 32'd1);
    reset = 1'b0;
    i_v   = 1'b1;
    i_d   = 8'h05;
    @(negedge clock);
    check("abort i_b in rst", 32'(i_b), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    i_v   = 1'b0;
    @(negedge clock);
    check("abort o_v", 32'(o_v), 32'd0);
    check("abort i_b", 32'(i_b), 32'd0);
    check("abort err", 32'(err), 32'd0);
    @(posedge clock);
    #1;
    tokq.delete();
    outq.delete();
    for (int c = 0; c < 20; c++) feed_cycle();
    check("abort no residue", 32'(outq.size()), 32'd0);

    // random traffic against the expansion model
    do_reset();
    expq.delete();
    exp_err = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 50)      tok = {1'b0, 7'($urandom_range(127))};
      else if (r < 55) tok = 8'h80;
      else if (r < 92) tok = {1'b1, 7'($urandom_range(4, 1))};
      else             tok = {1'b1, 7'($urandom_range(127, 1))};
      i_v = (c < 4700) && ($urandom_range(9) < 7);
      i_d = tok;
      o_b = (c < 4700) && ($urandom_range(3) == 0);
      @(negedge clock);
      check("rnd err", 32'(err), 32'(exp_err));
      if (!o_v) begin
        check("rnd idle empty", 32'(expq.size()), 32'd0);
        check("rnd idle i_b", 32'(i_b), 32'd0);
      end else if (o_b) begin
        check("rnd stall i_b", 32'(i_b), 32'd1);
      end
      if (o_v && !o_b) begin
        if (expq.size() == 0)
          check("rnd spurious", 32'd1, 32'd0);
        else
          check("rnd o_d", 32'(o_d), 32'(expq.pop_front()));
      end
      if (i_v && !i_b) begin
        if (!i_d[7])
          expq.push_back(i_d[6:0]);
        else if (i_d[6:0] == 7'd0)
          exp_err = 1'b1;
        else
          for (int z = 0; z < int'(i_d[6:0]); z++) expq.push_back(7'h00);
      end
      @(posedge clock);
      #1;
    end
    check("rnd drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/zle_dec_xcb.md
ZLE_DEC_XCB -- requirements
Module: zle_dec_xcB

Interface
REQ-001 The block SHALL have parameter W, default 7, meaning the output data width; the input token width is W+1.
REQ-002 clock  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
REQ-004 i_d  input  W+1  encoded token.
REQ-005 i_v  input  1  i_d valid.
REQ-006 i_b  output  1  back-pressure to the producer; 1 means the token is not taken.
REQ-007 o_d  output  W  decoded value.
REQ-008 o_v  output  1  o_d valid.
REQ-009 o_b  input  1  back-pressure from the consumer.
REQ-010 The block SHALL signal a sticky error on err  output  1: set by a malformed run token, cleared only by reset.

Function
REQ-011 A transfer SHALL occur on a stream exactly when v=1 and b=0 in the same cycle.
REQ-012 Token format: bit W=0 is a literal whose value is i_d[W-1:0]; bit W=1 is a run whose count is c=i_d[W-1:0].
REQ-013 Decoding: a literal SHALL emit one output equal to its value; a run with c=1..2^W-1 SHALL emit c outputs of 0.
REQ-014 A run with c=0 is malformed: it SHALL be consumed, SHALL emit no output, and SHALL set err.
REQ-015 State machine: EMPTY (o_v=0), HOLD (o_v=1, no pending zeros), RUN (o_v=1, o_d=0, rem>0 pending zeros after the current one).
REQ-016 i_b SHALL be combinational: i_b = (state==RUN) | (o_v & o_b).
REQ-017 Output drain: when an output transfer occurs in RUN, rem SHALL decrement; the state SHALL move to HOLD when rem reaches 0, with o_d held at 0.
REQ-018 Accepting a literal (from EMPTY, or from HOLD while the output transfers) SHALL load o_d=value, set o_v=1 the next cycle, and go to HOLD.
REQ-019 Accepting a run with c>=1 SHALL load o_d=0, o_v=1, rem=c-1, and go to RUN if rem>0, else HOLD.
REQ-020 In HOLD, if the output transfers and no token is accepted, the state SHALL go to EMPTY with o_v=0.
REQ-021 In HOLD, if the output transfers and a c=0 run is accepted, the state SHALL go to EMPTY.
REQ-022 Latency: an accepted token SHALL produce its first output on the following cycle.
REQ-023 Throughput: with o_b=0, the block SHALL sustain one literal per cycle; a c-zero run SHALL hold i_b=1 for c-1 cycles.
REQ-024 While o_b=1, o_d, o_v, rem and state SHALL hold.
REQ-025 rem SHALL be W bits wide and SHALL never wrap; the maximum value is 2^W-2.

Reset
REQ-026 When reset=0 at a clock edge, the block SHALL set state=EMPTY, o_v=0, o_d=0, rem=0 and err=0, aborting any run in progress with no residual zeros emitted.
REQ-027 While reset=0, i_b SHALL read 0 (from state EMPTY); any token presented during reset SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold the state encoding (EMPTY, HOLD, RUN), the token run-flag bit index, the count field width and the maximum count 2^W-1.
REQ-029 The block SHALL contain one sub-module, zle_dec_xcB_dp, holding the o_d register, the rem counter and the flags rem_eq_0 / i_cnt_eq_0; the FSM stays in the top level.
REQ-030 The block SHALL be lossless with the team's zero run-length encoder: encoder output fed back into this block SHALL reproduce the original 7-bit stream.

Verification
REQ-031 Literals 0x05, 0x7F, 0x00 back-to-back with o_b=0 -> o_d = 05, 7F, 00 on cycles t+1, t+2, t+3; i_b stays 0.
REQ-032 Run token 0x83, then literal 0x11 -> outputs 00, 00, 00, 11; i_b=1 for 2 cycles; 0x11 is accepted on the cycle the third zero transfers.
REQ-033 Run token 0xFF, then 0x01 -> exactly 127 zeros followed by 01; rem never exceeds 126.
REQ-034 0x80 between literals 0x02 and 0x03 -> outputs 02, 03 only; err=1 and remains 1 until reset.
REQ-035 o_b=1 for 5 cycles mid-run of 0x84 -> o_d/o_v frozen; exactly 4 zeros are still emitted in total.
REQ-036 reset=0 during a 0x90 run, after 3 zeros -> next cycle o_v=0, i_b=0, err=0; no further zeros are emitted.
